// File: rtl/glb_cgra_strm_bridge.sv
// glb_cgra_strm_bridge
// Sits between the global buffer tiles and the CGRA PRRs. Each channel has
// a run-time programmable latency pipe in each stream direction (g2f and f2g),
// a registered config column select, and saturating valid-word counters.
// A latency of zero is a pure combinational bypass. Any non-zero latency is a
// shift pipe tapped at stage L-1.

module glb_cgra_strm_bridge #(
    parameter int NUM_CH         = 16,
    parameter int NUM_COL        = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int CFG_ADDR_WIDTH = 32,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int MAX_LAT        = 8,
    parameter int LW             = $clog2(MAX_LAT + 1),
    localparam int CSW           = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CH*LW-1:0]                       lat_g2f,
    input  logic [NUM_CH*LW-1:0]                       lat_f2g,
    input  logic [NUM_CH*CSW-1:0]                      cfg_col_sel,
    input  logic [NUM_CH-1:0]                          flush,
    input  logic                                       cnt_clr,
    input  logic [NUM_CH*NUM_COL-1:0]                  g2f_ctrl_in,
    input  logic [NUM_CH*NUM_COL*DATA_WIDTH-1:0]       g2f_data_in,
    output logic [NUM_CH*NUM_COL-1:0]                  g2f_ctrl_out,
    output logic [NUM_CH*NUM_COL*DATA_WIDTH-1:0]       g2f_data_out,
    input  logic [NUM_CH*NUM_COL-1:0]                  f2g_ctrl_in,
    input  logic [NUM_CH*NUM_COL*DATA_WIDTH-1:0]       f2g_data_in,
    output logic [NUM_CH*NUM_COL-1:0]                  f2g_ctrl_out,
    output logic [NUM_CH*NUM_COL*DATA_WIDTH-1:0]       f2g_data_out,
    input  logic [NUM_CH*NUM_COL-1:0]                  glb_cfg_wr_en,
    input  logic [NUM_CH*NUM_COL-1:0]                  glb_cfg_rd_en,
    input  logic [NUM_CH*NUM_COL*CFG_ADDR_WIDTH-1:0]   glb_cfg_addr,
    input  logic [NUM_CH*NUM_COL*CFG_DATA_WIDTH-1:0]   glb_cfg_data,
    output logic [NUM_CH-1:0]                          cgra_cfg_wr_en,
    output logic [NUM_CH-1:0]                          cgra_cfg_rd_en,
    output logic [NUM_CH*CFG_ADDR_WIDTH-1:0]           cgra_cfg_addr,
    output logic [NUM_CH*CFG_DATA_WIDTH-1:0]           cgra_cfg_data,
    input  logic [NUM_CH*CFG_DATA_WIDTH-1:0]           cgra_cfg_rd_data,
    output logic [NUM_CH*CFG_DATA_WIDTH-1:0]           glb_cfg_rd_data,
    output logic [NUM_CH*16-1:0]                       g2f_cnt,
    output logic [NUM_CH*16-1:0]                       f2g_cnt
);

    localparam int CW    = NUM_COL * DATA_WIDTH;
    localparam int CNT_W = 16;

    // Latency fields wider than the pipe are clamped to the deepest tap.
    function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
        logic [LW-1:0] res;
        if (lat > LW'(MAX_LAT)) begin
            res = LW'(MAX_LAT);
        end else begin
            res = lat;
        end
        return res;
    endfunction

    // Adds the number of valid columns to a counter, sticking at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [NUM_COL-1:0] vld);
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] res;
        sum = {1'b0, cnt};
        for (int c = 0; c < NUM_COL; c++) begin
            sum = sum + {{CNT_W{1'b0}}, vld[c]};
        end
        if (sum[CNT_W]) begin
            res = {CNT_W{1'b1}};
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

        // d == 0 is the g2f pipe, d == 1 is the f2g pipe
        for (genvar d = 0; d < 2; d++) begin : g_dir
            logic [NUM_COL-1:0] ctrl_r [MAX_LAT];
            logic [CW-1:0]      data_r [MAX_LAT];
            logic [LW-1:0]      shadow_r;
            logic [LW-1:0]      lat_raw_s;
            logic [LW-1:0]      lat_eff_s;
            logic               mismatch_s;
            logic               clear_s;
            logic [NUM_COL-1:0] in_ctrl_s;
            logic [NUM_COL-1:0] out_ctrl_s;
            logic [NUM_COL-1:0] tap_ctrl_s;
            logic [CW-1:0]      in_data_s;
            logic [CW-1:0]      out_data_s;
            logic [CW-1:0]      tap_data_s;
            logic [CNT_W-1:0]   cnt_r;

            if (d == 0) begin : g_io
                assign lat_raw_s = lat_g2f[ch*LW +: LW];
                assign in_ctrl_s = g2f_ctrl_in[ch*NUM_COL +: NUM_COL];
                assign in_data_s = g2f_data_in[ch*CW +: CW];
                assign g2f_ctrl_out[ch*NUM_COL +: NUM_COL] = out_ctrl_s;
                assign g2f_data_out[ch*CW +: CW]           = out_data_s;
                assign g2f_cnt[ch*CNT_W +: CNT_W]          = cnt_r;
            end else begin : g_io
                assign lat_raw_s = lat_f2g[ch*LW +: LW];
                assign in_ctrl_s = f2g_ctrl_in[ch*NUM_COL +: NUM_COL];
                assign in_data_s = f2g_data_in[ch*CW +: CW];
                assign f2g_ctrl_out[ch*NUM_COL +: NUM_COL] = out_ctrl_s;
                assign f2g_data_out[ch*CW +: CW]           = out_data_s;
                assign f2g_cnt[ch*CNT_W +: CNT_W]          = cnt_r;
            end

            assign lat_eff_s  = clamp_lat(lat_raw_s);
            assign mismatch_s = (lat_eff_s != shadow_r);
            assign clear_s    = mismatch_s | flush[ch];

            // Shadow of the last applied latency; a difference triggers a pipe flush
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_r <= '0;
                end else begin
                    shadow_r <= lat_eff_s;
                end
            end

            // Valid stages; flush or latency change drops everything, including this cycle's input
            always_ff @(posedge clk) begin
                if (reset || clear_s) begin
                    for (int j = 0; j < MAX_LAT; j++) begin
                        ctrl_r[j] <= '0;
                    end
                end else begin
                    ctrl_r[0] <= in_ctrl_s;
                    for (int j = 1; j < MAX_LAT; j++) begin
                        ctrl_r[j] <= ctrl_r[j-1];
                    end
                end
            end

            // Data stages shift freely; stale data is harmless once its valid is gone
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j < MAX_LAT; j++) begin
                        data_r[j] <= '0;
                    end
                end else begin
                    data_r[0] <= in_data_s;
                    for (int j = 1; j < MAX_LAT; j++) begin
                        data_r[j] <= data_r[j-1];
                    end
                end
            end

            // AND-OR tap select at stage L-1
            always_comb begin
                tap_ctrl_s = '0;
                tap_data_s = '0;
                for (int j = 0; j < MAX_LAT; j++) begin
                    tap_ctrl_s = tap_ctrl_s | ({NUM_COL{lat_eff_s == LW'(j + 1)}} & ctrl_r[j]);
                    tap_data_s = tap_data_s | ({CW{lat_eff_s == LW'(j + 1)}} & data_r[j]);
                end
            end

            // Bypass at zero latency; valids are masked while a latency change is pending
            always_comb begin
                out_ctrl_s = in_ctrl_s;
                out_data_s = in_data_s;
                if (lat_eff_s == '0) begin
                    out_ctrl_s = in_ctrl_s;
                    out_data_s = in_data_s;
                end else begin
                    out_ctrl_s = mismatch_s ? '0 : tap_ctrl_s;
                    out_data_s = tap_data_s;
                end
            end

            // Saturating count of valid words leaving the pipe; clear beats counting
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_r <= '0;
                end else if (cnt_clr) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= sat_add(cnt_r, out_ctrl_s);
                end
            end
        end

        logic [CSW-1:0]            col_sel_s;
        logic                      sel_wr_s;
        logic                      sel_rd_s;
        logic [CFG_ADDR_WIDTH-1:0] sel_addr_s;
        logic [CFG_DATA_WIDTH-1:0] sel_data_s;
        logic                      cfg_wr_r;
        logic                      cfg_rd_r;
        logic [CFG_ADDR_WIDTH-1:0] cfg_addr_r;
        logic [CFG_DATA_WIDTH-1:0] cfg_data_r;
        logic [CFG_DATA_WIDTH-1:0] rd_data_r;

        assign col_sel_s = cfg_col_sel[ch*CSW +: CSW];

        // Config column mux; a selector past the last column matches nothing
        always_comb begin
            sel_wr_s   = 1'b0;
            sel_rd_s   = 1'b0;
            sel_addr_s = '0;
            sel_data_s = '0;
            for (int c = 0; c < NUM_COL; c++) begin
                sel_wr_s   = sel_wr_s | ((col_sel_s == CSW'(c)) & glb_cfg_wr_en[ch*NUM_COL + c]);
                sel_rd_s   = sel_rd_s | ((col_sel_s == CSW'(c)) & glb_cfg_rd_en[ch*NUM_COL + c]);
                sel_addr_s = sel_addr_s | ({CFG_ADDR_WIDTH{col_sel_s == CSW'(c)}}
                             & glb_cfg_addr[(ch*NUM_COL + c)*CFG_ADDR_WIDTH +: CFG_ADDR_WIDTH]);
                sel_data_s = sel_data_s | ({CFG_DATA_WIDTH{col_sel_s == CSW'(c)}}
                             & glb_cfg_data[(ch*NUM_COL + c)*CFG_DATA_WIDTH +: CFG_DATA_WIDTH]);
            end
        end

        // One register stage on the config path in both directions
        always_ff @(posedge clk) begin
            if (reset) begin
                cfg_wr_r   <= 1'b0;
                cfg_rd_r   <= 1'b0;
                cfg_addr_r <= '0;
                cfg_data_r <= '0;
                rd_data_r  <= '0;
            end else begin
                cfg_wr_r   <= sel_wr_s;
                cfg_rd_r   <= sel_rd_s;
                cfg_addr_r <= sel_addr_s;
                cfg_data_r <= sel_data_s;
                rd_data_r  <= cgra_cfg_rd_data[ch*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
            end
        end

        assign cgra_cfg_wr_en[ch]                                  = cfg_wr_r;
        assign cgra_cfg_rd_en[ch]                                  = cfg_rd_r;
        assign cgra_cfg_addr[ch*CFG_ADDR_WIDTH +: CFG_ADDR_WIDTH]  = cfg_addr_r;
        assign cgra_cfg_data[ch*CFG_DATA_WIDTH +: CFG_DATA_WIDTH]  = cfg_data_r;
        assign glb_cfg_rd_data[ch*CFG_DATA_WIDTH +: CFG_DATA_WIDTH] = rd_data_r;
    end

endmodule

// File: tb/tb_glb_cgra_strm_bridge.sv
// Self-checking bench for glb_cgra_strm_bridge: latency vector table with a
// scoreboard, plus directed flush, latency-change, config, saturation and
// mid-stream reset sequences.

module tb_glb_cgra_strm_bridge;

    localparam int NUM_CH  = 16;
    localparam int NUM_COL = 2;
    localparam int DW      = 16;
    localparam int AW      = 32;
    localparam int CDW     = 32;
    localparam int MAX_LAT = 8;
    localparam int LW      = 4;
    localparam int CSW     = 1;
    localparam int NW      = NUM_CH * NUM_COL;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_CH*LW-1:0]   lat_g2f, lat_f2g;
    logic [NUM_CH*CSW-1:0]  cfg_col_sel;
    logic [NUM_CH-1:0]      flush;
    logic                   cnt_clr;
    logic [NW-1:0]          g2f_ctrl_in, g2f_ctrl_out, f2g_ctrl_in, f2g_ctrl_out;
    logic [NW*DW-1:0]       g2f_data_in, g2f_data_out, f2g_data_in, f2g_data_out;
    logic [NW-1:0]          glb_cfg_wr_en, glb_cfg_rd_en;
    logic [NW*AW-1:0]       glb_cfg_addr;
    logic [NW*CDW-1:0]      glb_cfg_data;
    logic [NUM_CH-1:0]      cgra_cfg_wr_en, cgra_cfg_rd_en;
    logic [NUM_CH*AW-1:0]   cgra_cfg_addr;
    logic [NUM_CH*CDW-1:0]  cgra_cfg_data, cgra_cfg_rd_data, glb_cfg_rd_data;
    logic [NUM_CH*16-1:0]   g2f_cnt, f2g_cnt;

    glb_cgra_strm_bridge dut (
        .clk(clk), .reset(reset), .lat_g2f(lat_g2f), .lat_f2g(lat_f2g),
        .cfg_col_sel(cfg_col_sel), .flush(flush), .cnt_clr(cnt_clr),
        .g2f_ctrl_in(g2f_ctrl_in), .g2f_data_in(g2f_data_in),
        .g2f_ctrl_out(g2f_ctrl_out), .g2f_data_out(g2f_data_out),
        .f2g_ctrl_in(f2g_ctrl_in), .f2g_data_in(f2g_data_in),
        .f2g_ctrl_out(f2g_ctrl_out), .f2g_data_out(f2g_data_out),
        .glb_cfg_wr_en(glb_cfg_wr_en), .glb_cfg_rd_en(glb_cfg_rd_en),
        .glb_cfg_addr(glb_cfg_addr), .glb_cfg_data(glb_cfg_data),
        .cgra_cfg_wr_en(cgra_cfg_wr_en), .cgra_cfg_rd_en(cgra_cfg_rd_en),
        .cgra_cfg_addr(cgra_cfg_addr), .cgra_cfg_data(cgra_cfg_data),
        .cgra_cfg_rd_data(cgra_cfg_rd_data), .glb_cfg_rd_data(glb_cfg_rd_data),
        .g2f_cnt(g2f_cnt), .f2g_cnt(f2g_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        int          col;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          dir;
        int          ch;
        int          col;
        logic [3:0]  lat;
        int          exp_lat;
        logic [15:0] data;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_streams();
        g2f_ctrl_in = '0;
        f2g_ctrl_in = '0;
        g2f_data_in = '0;
        f2g_data_in = '0;
    endtask

    task automatic set_lat(input int dir, input int ch, input logic [3:0] v);
        if (dir == 0) lat_g2f[ch*LW +: LW] = v;
        else          lat_f2g[ch*LW +: LW] = v;
    endtask

    task automatic drive_word(input int dir, input int ch, input int col, input logic [15:0] dat);
        if (dir == 0) begin
            g2f_ctrl_in[ch*NUM_COL + col]          = 1'b1;
            g2f_data_in[(ch*NUM_COL + col)*DW +: DW] = dat;
        end else begin
            f2g_ctrl_in[ch*NUM_COL + col]          = 1'b1;
            f2g_data_in[(ch*NUM_COL + col)*DW +: DW] = dat;
        end
    endtask

    function automatic logic [1:0] out_ctrl(input int dir, input int ch);
        return (dir == 0) ? g2f_ctrl_out[ch*NUM_COL +: NUM_COL] : f2g_ctrl_out[ch*NUM_COL +: NUM_COL];
    endfunction

    function automatic logic [15:0] out_data(input int dir, input int ch, input int col);
        return (dir == 0) ? g2f_data_out[(ch*NUM_COL + col)*DW +: DW]
                          : f2g_data_out[(ch*NUM_COL + col)*DW +: DW];
    endfunction

    function automatic logic [15:0] cnt_of(input int dir, input int ch);
        return (dir == 0) ? g2f_cnt[ch*16 +: 16] : f2g_cnt[ch*16 +: 16];
    endfunction

    // Any valid on the watched channel must match the oldest scoreboard entry
    task automatic monitor(input int dir, input int ch, input int cyc, input string tag);
        logic [1:0]  oc;
        logic [15:0] od;
        exp_t        e;
        oc = out_ctrl(dir, ch);
        if (oc != 2'b00) begin
            if (sb.size() == 0) begin
                chk({tag, "_spurious"}, 64'(oc), 64'd0);
            end else begin
                e  = sb.pop_front();
                od = out_data(dir, ch, e.col);
                chk({tag, "_word"}, {16'(cyc), 14'd0, oc, 16'd0, od},
                    {16'(e.due), 14'd0, 2'(1 << e.col), 16'd0, e.data});
            end
        end
    endtask

    initial begin
        vecs[0] = '{dir: 0, ch: 0,  col: 0, lat: 4'd3,  exp_lat: 3, data: 16'hA5A5};
        vecs[1] = '{dir: 1, ch: 1,  col: 1, lat: 4'd0,  exp_lat: 0, data: 16'h1234};
        vecs[2] = '{dir: 1, ch: 1,  col: 1, lat: 4'd12, exp_lat: 8, data: 16'hBEEF};
        vecs[3] = '{dir: 0, ch: 5,  col: 1, lat: 4'd1,  exp_lat: 1, data: 16'h0F0F};
        vecs[4] = '{dir: 0, ch: 15, col: 0, lat: 4'd8,  exp_lat: 8, data: 16'h8001};
        vecs[5] = '{dir: 1, ch: 7,  col: 0, lat: 4'd15, exp_lat: 8, data: 16'h7777};
        vecs[6] = '{dir: 1, ch: 3,  col: 1, lat: 4'd5,  exp_lat: 5, data: 16'hC3C3};

        reset = 1'b1;
        lat_g2f = '0; lat_f2g = '0; cfg_col_sel = '0; flush = '0; cnt_clr = 1'b0;
        clear_streams();
        glb_cfg_wr_en = '0; glb_cfg_rd_en = '0; glb_cfg_addr = '0; glb_cfg_data = '0;
        cgra_cfg_rd_data = '0;
        repeat (10) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_g2f_cnt", 64'($countones(g2f_cnt)), 64'd0);
        chk("rst_f2g_cnt", 64'($countones(f2g_cnt)), 64'd0);
        chk("rst_g2f_ctrl", 64'(g2f_ctrl_out), 64'd0);
        chk("rst_cfg_wr", 64'(cgra_cfg_wr_en), 64'd0);
        chk("rst_rd_data", 64'($countones(glb_cfg_rd_data)), 64'd0);

        // Latency table: single pulse, must appear exactly exp_lat cycles later
        for (int v = 0; v < 7; v++) begin
            clear_streams();
            set_lat(vecs[v].dir, vecs[v].ch, vecs[v].lat);
            cnt_clr = 1'b1;
            tick();
            cnt_clr = 1'b0;
            tick();
            tick();
            for (int k = 0; k <= MAX_LAT + 2; k++) begin
                clear_streams();
                if (k == 0) begin
                    drive_word(vecs[v].dir, vecs[v].ch, vecs[v].col, vecs[v].data);
                    sb.push_back('{due: vecs[v].exp_lat, col: vecs[v].col, data: vecs[v].data});
                end
                #1;
                monitor(vecs[v].dir, vecs[v].ch, k, $sformatf("lat_v%0d", v));
                tick();
            end
            chk($sformatf("lat_v%0d_missing", v), 64'(sb.size()), 64'd0);
            chk($sformatf("lat_v%0d_cnt", v), 64'(cnt_of(vecs[v].dir, vecs[v].ch)), 64'd1);
            sb.delete();
        end

        // Flush: lat 4, 10 words, flush on the 3rd -> inputs 4..10 survive
        clear_streams();
        set_lat(0, 0, 4'd4);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            clear_streams();
            flush = '0;
            if (k < 10) begin
                drive_word(0, 0, 0, 16'h0100 + 16'(k));
                if (k >= 3) sb.push_back('{due: k + 4, col: 0, data: 16'h0100 + 16'(k)});
            end
            if (k == 2) flush[0] = 1'b1;
            #1;
            monitor(0, 0, k, "flush");
            tick();
        end
        flush = '0;
        chk("flush_missing", 64'(sb.size()), 64'd0);
        chk("flush_cnt", 64'(cnt_of(0, 0)), 64'd7);
        sb.delete();

        // Latency change 4 -> 2 in an idle cycle: in-flight words dropped
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int k = 0; k < 15; k++) begin
            clear_streams();
            if (k < 3) drive_word(0, 0, 0, 16'h0200 + 16'(k));
            if (k == 3) set_lat(0, 0, 4'd2);
            if (k >= 4 && k < 10) begin
                drive_word(0, 0, 0, 16'h0200 + 16'(k));
                sb.push_back('{due: k + 2, col: 0, data: 16'h0200 + 16'(k)});
            end
            #1;
            monitor(0, 0, k, "latchg");
            tick();
        end
        chk("latchg_missing", 64'(sb.size()), 64'd0);
        chk("latchg_cnt", 64'(cnt_of(0, 0)), 64'd6);
        sb.delete();

        // Config column select: col 1 wins, col 0 strobe ignored
        clear_streams();
        cfg_col_sel[2*CSW +: CSW] = 1'b1;
        glb_cfg_wr_en[2*NUM_COL + 1] = 1'b1;
        glb_cfg_wr_en[2*NUM_COL + 0] = 1'b1;
        glb_cfg_addr[(2*NUM_COL + 1)*AW +: AW]  = 32'h0000_0104;
        glb_cfg_data[(2*NUM_COL + 1)*CDW +: CDW] = 32'hDEAD_BEEF;
        glb_cfg_addr[(2*NUM_COL + 0)*AW +: AW]  = 32'h0000_0999;
        glb_cfg_data[(2*NUM_COL + 0)*CDW +: CDW] = 32'h1111_2222;
        cgra_cfg_rd_data[2*CDW +: CDW] = 32'h0000_0055;
        #1;
        chk("cfg_wr_early", 64'(cgra_cfg_wr_en), 64'd0);
        chk("cfg_rd_data_early", 64'(glb_cfg_rd_data[2*CDW +: CDW]), 64'd0);
        tick();
        glb_cfg_wr_en = '0;
        glb_cfg_addr = '0;
        glb_cfg_data = '0;
        chk("cfg_wr_pulse", 64'(cgra_cfg_wr_en), 64'h0004);
        chk("cfg_addr", 64'(cgra_cfg_addr[2*AW +: AW]), 64'h0000_0104);
        chk("cfg_data", 64'(cgra_cfg_data[2*CDW +: CDW]), 64'hDEAD_BEEF);
        chk("cfg_rd_data", 64'(glb_cfg_rd_data[2*CDW +: CDW]), 64'h0000_0055);
        tick();
        chk("cfg_wr_end", 64'(cgra_cfg_wr_en), 64'd0);
        glb_cfg_rd_en[9*NUM_COL + 1] = 1'b1;
        tick();
        glb_cfg_rd_en = '0;
        chk("cfg_rd_wrong_col", 64'(cgra_cfg_rd_en), 64'd0);
        glb_cfg_rd_en[9*NUM_COL + 0] = 1'b1;
        tick();
        glb_cfg_rd_en = '0;
        chk("cfg_rd_pulse", 64'(cgra_cfg_rd_en), 64'h0200);

        // Counter saturation on ch4 in bypass with both columns valid
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        g2f_ctrl_in[4*NUM_COL +: NUM_COL] = 2'b11;
        repeat (32767) tick();
        chk("sat_below", 64'(cnt_of(0, 4)), 64'hFFFE);
        tick();
        chk("sat_hit", 64'(cnt_of(0, 4)), 64'hFFFF);
        tick();
        tick();
        chk("sat_hold", 64'(cnt_of(0, 4)), 64'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_priority", 64'(cnt_of(0, 4)), 64'd0);
        tick();
        chk("clr_resume", 64'(cnt_of(0, 4)), 64'd2);
        clear_streams();

        // Reset in the middle of a lat 5 stream
        set_lat(0, 6, 4'd5);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            clear_streams();
            drive_word(0, 6, 1, 16'h0600 + 16'(k));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_streams();
        chk("mrst_g2f_ctrl", 64'(g2f_ctrl_out), 64'd0);
        chk("mrst_f2g_ctrl", 64'(f2g_ctrl_out), 64'd0);
        chk("mrst_g2f_data", 64'($countones(g2f_data_out)), 64'd0);
        chk("mrst_g2f_cnt", 64'($countones(g2f_cnt)), 64'd0);
        chk("mrst_f2g_cnt", 64'($countones(f2g_cnt)), 64'd0);
        chk("mrst_rd_data", 64'($countones(glb_cfg_rd_data)), 64'd0);
        for (int k = 0; k < 12; k++) begin
            #1;
            monitor(0, 6, k, "mrst");
            tick();
        end
        chk("mrst_cnt_after", 64'(cnt_of(0, 6)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_cgra_strm_bridge.md
Name: glb_cgra_strm_bridge

Overview:
Parametrised, cycle-accurate bridge between global_buffer tile ports and cgra PRR ports. It replaces fixed wiring with per-channel, run-time programmable latency pipes in both stream directions. It adds a selectable configuration column, per-channel flush and saturating transfer counters. It sits between global_buffer and cgra in the top-level integration and in the GLB testbench.

Parameters:
NUM_CH, 16, number of channels (one per GLB tile / PRR)
NUM_COL, 2, columns per channel (CGRA_PER_GLB)
DATA_WIDTH, 16, stream data width
CFG_ADDR_WIDTH, 32, CGRA config address width
CFG_DATA_WIDTH, 32, CGRA config data width
MAX_LAT, 8, maximum pipe depth in cycles (>=1)
LW, $clog2(MAX_LAT+1), latency field width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
lat_g2f  in  NUM_CH*LW  per-channel g2f latency
lat_f2g  in  NUM_CH*LW  per-channel f2g latency
cfg_col_sel  in  NUM_CH*$clog2(NUM_COL)  column that carries config per channel
flush  in  NUM_CH  per-channel pipe flush pulse
cnt_clr  in  1  clear all counters
g2f_ctrl_in / g2f_data_in  in  NUM_CH*NUM_COL / *DATA_WIDTH  from GLB
g2f_ctrl_out / g2f_data_out  out  same  to CGRA
f2g_ctrl_in / f2g_data_in  in  same  from CGRA
f2g_ctrl_out / f2g_data_out  out  same  to GLB
glb_cfg_wr_en, glb_cfg_rd_en  in  NUM_CH*NUM_COL  GLB config strobes
glb_cfg_addr / glb_cfg_data  in  NUM_CH*NUM_COL*CFG_ADDR_WIDTH / CFG_DATA_WIDTH
cgra_cfg_wr_en, cgra_cfg_rd_en  out  NUM_CH
cgra_cfg_addr / cgra_cfg_data  out  NUM_CH*CFG_ADDR_WIDTH / CFG_DATA_WIDTH
cgra_cfg_rd_data  in  NUM_CH*CFG_DATA_WIDTH
glb_cfg_rd_data  out  NUM_CH*CFG_DATA_WIDTH
g2f_cnt, f2g_cnt  out  NUM_CH*16  valid-word counters

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on posedge clk.
- Reset state: all pipe stages have ctrl=0 and data=0. All outputs are 0. Counters are 0. The latency shadow registers are 0.
- Latency field L: effective L_eff = min(L, MAX_LAT).
  - L_eff = 0: combinational bypass, out = in in the same cycle.
  - L_eff = k >= 1: out at cycle t+k equals in at cycle t, for ctrl and data of every column.
- Latency change: each channel/direction holds a shadow of its last L_eff. In the cycle after a mismatch is detected, that pipe is flushed (all ctrl stages cleared) and the shadow is updated. Words in flight are dropped. Data stages need not be cleared.
- flush[i]: on posedge, clears ctrl in every stage of both pipes of channel i. The input word sampled in the same cycle is also dropped, so the first word to survive is the one presented in the cycle after flush. Bypass mode (L_eff=0) is unaffected by flush.
- Config path: one register stage.
  - cgra_cfg_wr_en[i] and cgra_cfg_rd_en[i] are registered from column cfg_col_sel[i]; strobes on other columns are ignored.
  - addr and data are registered from the same column.
  - glb_cfg_rd_data[i] = cgra_cfg_rd_data[i], registered one cycle.
  - cfg_col_sel >= NUM_COL: strobes forced to 0.
- Counters: g2f_cnt[i] increments by the popcount of g2f_ctrl_out[i] each cycle, saturating at 16'hFFFF with no wrap. f2g_cnt behaves the same on f2g_ctrl_out.
  - cnt_clr has priority: counters read 0 next cycle, and that cycle's valids are not counted.
  - Reset has priority over everything.
- Reset asserted mid-stream: all in-flight words are lost and outputs are 0 in the following cycle.

Test Plan:
- reset 10 cycles, then lat_g2f[0]=3, ctrl pulse with data 16'hA5A5 at cycle 20 on col 0 -> g2f_ctrl_out[0][0]=1, data=16'hA5A5 at cycle 23 only; g2f_cnt[0]=1.
- lat_f2g[1]=0, drive f2g_data_in[1][1]=16'h1234 with ctrl=1 -> f2g_data_out[1][1]=16'h1234 in the same cycle; set lat=12 with MAX_LAT=8 -> latency measured as 8.
- lat=4, stream 10 consecutive words, assert flush[0] at the 3rd input cycle -> exactly 7 words emerge (the 4th..10th inputs), with the first appearing 4 cycles after the 4th input; change lat from 4 to 2 mid-stream -> in-flight words dropped, next input appears after 2 cycles.
- cfg_col_sel[2]=1, wr_en on col 1 with addr 32'h0000_0104, data 32'hDEAD_BEEF, plus a simultaneous col 0 wr_en -> one cgra_cfg_wr_en[2] pulse one cycle later carrying col-1 addr/data; cgra_cfg_rd_data=32'h55 -> glb_cfg_rd_data=32'h55 one cycle later.
- preload counter near saturation by streaming 2 valid columns for 32768 cycles -> g2f_cnt holds 16'hFFFF; cnt_clr with valid in the same cycle -> 0 next cycle.
- assert reset during a lat=5 stream -> all outputs and counters 0 the next cycle; no stale word emerges after reset deasserts.
